// File: rtl/f1_start_ctrl_if.sv
// f1_start_ctrl_if: start request, player button and lamp handshake between the start sequencer and its environment
interface f1_start_ctrl_if #(parameter int REACT_W = 16);
  logic trigger;
  logic react;
  logic [7:0] lights_in;
  logic light_en;
  logic light_rst;
  logic busy;
  logic [6:0] hold_ticks;
  logic [REACT_W-1:0] reaction_time;
  logic time_valid;
  logic jump_start;
  modport master(output trigger, react, lights_in, input light_en, light_rst, busy, hold_ticks, reaction_time, time_valid, jump_start);
  modport slave(input trigger, react, lights_in, output light_en, light_rst, busy, hold_ticks, reaction_time, time_valid, jump_start);
endinterface

// File: rtl/f1_start_ctrl.sv
// f1_start_ctrl: race-start sequencer stepping the F1 lamps, holding a random delay and timing the player's reaction
module f1_start_ctrl #(
  parameter int TICK_CYCLES = 16,
  parameter int DELAY_MIN = 4,
  parameter int REACT_W = 16
) (
  input logic clk,
  input logic rst,
  f1_start_ctrl_if.slave io
);
  typedef enum logic [2:0] {IDLE, ARM, COUNT, HOLD, TIMING, DONE, JUMP} state_t;
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TICK_CYCLES - 1);
  state_t state, state_nx;
  logic [TW-1:0] tick_cnt;
  logic [7:0] delay;
  logic [6:0] lfsr;
  logic [REACT_W-1:0] react_cnt;
  logic tick_end, full;
  assign tick_end = tick_cnt == TLAST;
  assign full = io.lights_in == 8'hFF;
  assign io.busy = state inside {ARM, COUNT, HOLD, TIMING};
  always_comb begin
    state_nx = state;
    io.light_en = 1'b0;
    io.light_rst = 1'b0;
    case (state)
      IDLE, DONE, JUMP: state_nx = io.trigger ? ARM : state;
      ARM: begin
        io.light_rst = 1'b1;
        state_nx = COUNT;
      end
      COUNT: begin
        io.light_rst = io.react;
        io.light_en = !io.react && !full && tick_end;
        state_nx = io.react ? JUMP : full ? HOLD : COUNT;
      end
      HOLD: begin
        io.light_rst = io.react;
        io.light_en = !io.react && tick_end && delay == 8'd1;
        state_nx = io.react ? JUMP : io.light_en ? TIMING : HOLD;
      end
      TIMING: state_nx = io.react ? DONE : TIMING;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr <= 7'h01;
      tick_cnt <= '0;
      delay <= '0;
      react_cnt <= '0;
      io.hold_ticks <= '0;
      io.reaction_time <= '0;
      io.time_valid <= 1'b0;
      io.jump_start <= 1'b0;
    end else begin
      state <= state_nx;
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      tick_cnt <= ((state == COUNT && !full) || state == HOLD) && !tick_end ? tick_cnt + 1'b1 : '0;
      react_cnt <= state == TIMING ? (&react_cnt ? react_cnt : react_cnt + 1'b1) : '0;
      if (state == COUNT && full && !io.react) begin
        io.hold_ticks <= lfsr;
        delay <= 8'(DELAY_MIN) + {1'b0, lfsr};
      end else if (state == HOLD && tick_end) begin
        delay <= delay - 1'b1;
      end
      if (state == TIMING && io.react) begin
        io.reaction_time <= react_cnt;
        io.time_valid <= 1'b1;
      end
      if ((state == COUNT || state == HOLD) && io.react) io.jump_start <= 1'b1;
      if (state_nx == ARM) begin
        io.time_valid <= 1'b0;
        io.jump_start <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_f1_start_ctrl.sv
// tb_f1_start_ctrl: drives two sequencers (16-bit and 4-bit reaction counters) with lamp FSMs against a phase/duration model
module tb_f1_start_ctrl;
  localparam int T = 4;
  localparam int DMIN = 2;
  localparam int P_IDLE = 0, P_ARM = 1, P_COUNT = 2, P_HOLD = 3, P_TIMING = 4, P_DONE = 5, P_JUMP = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] lights16 = 8'h00;
  logic [7:0] lights4 = 8'h00;
  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] seq [127];
  bit used [128];
  int ph = P_IDLE, k = 0, lamps = 0, e_hold = 0, e_rt16 = 0, e_rt4 = 0, m_cyc = 0;
  bit e_tv = 0, e_js = 0, m_valid = 0;

  f1_start_ctrl_if #(.REACT_W(16)) bus();
  f1_start_ctrl_if #(.REACT_W(4)) bus4();
  f1_start_ctrl #(.TICK_CYCLES(T), .DELAY_MIN(DMIN), .REACT_W(16)) dut (.clk(clk), .rst(rst), .io(bus));
  f1_start_ctrl #(.TICK_CYCLES(T), .DELAY_MIN(DMIN), .REACT_W(4)) dut4 (.clk(clk), .rst(rst), .io(bus4));

  always #5 clk = ~clk;
  assign bus.lights_in = lights16;
  assign bus4.lights_in = lights4;
  assign bus4.trigger = bus.trigger;
  assign bus4.react = bus.react;

  // light FSMs: 00 -> 01 -> 03 -> ... -> FF -> 00, cleared by rst or light_rst
  always @(posedge clk) begin
    lights16 <= (rst || bus.light_rst) ? 8'h00 : bus.light_en ? (lights16 == 8'hFF ? 8'h00 : {lights16[6:0], 1'b1}) : lights16;
    lights4 <= (rst || bus4.light_rst) ? 8'h00 : bus4.light_en ? (lights4 == 8'hFF ? 8'h00 : {lights4[6:0], 1'b1}) : lights4;
  end

  initial begin
    logic [6:0] l;
    l = 7'h01;
    for (int i = 0; i < 127; i++) begin
      seq[i] = l;
      l = {l[5:0], l[6] ^ l[5]};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: COUNT lasts 8*T+1 cycles with a pulse at every T-th, HOLD lasts (DMIN+h)*T cycles, TIMING k = reaction count
  always @(negedge clk) begin
    int dur, nph;
    bit x_en, x_rst, x_busy;
    logic [7:0] x_l;
    dur = (DMIN + e_hold) * T;
    x_busy = ph == P_ARM || ph == P_COUNT || ph == P_HOLD || ph == P_TIMING;
    x_rst = ph == P_ARM || ((ph == P_COUNT || ph == P_HOLD) && bus.react);
    x_en = !bus.react && ((ph == P_COUNT && (k + 1) % T == 0) || (ph == P_HOLD && k == dur - 1));
    x_l = 8'((1 << lamps) - 1);
    if (m_valid) begin
      chk("busy", bus.busy, x_busy);
      chk("light_en", bus.light_en, x_en);
      chk("light_rst", bus.light_rst, x_rst);
      chk("hold_ticks", bus.hold_ticks, e_hold);
      chk("reaction_time", bus.reaction_time, e_rt16);
      chk("time_valid", bus.time_valid, e_tv);
      chk("jump_start", bus.jump_start, e_js);
      chk("lights_in", lights16, x_l);
      chk("busy_w4", bus4.busy, x_busy);
      chk("light_en_w4", bus4.light_en, x_en);
      chk("light_rst_w4", bus4.light_rst, x_rst);
      chk("hold_ticks_w4", bus4.hold_ticks, e_hold);
      chk("reaction_time_w4", bus4.reaction_time, e_rt4);
      chk("time_valid_w4", bus4.time_valid, e_tv);
      chk("jump_start_w4", bus4.jump_start, e_js);
      chk("lights_in_w4", lights4, x_l);
    end
    nph = ph;
    if (rst) begin
      nph = P_IDLE;
      lamps <= 0;
      e_hold <= 0;
      e_rt16 <= 0;
      e_rt4 <= 0;
      e_tv <= 0;
      e_js <= 0;
      m_valid <= 1;
    end else begin
      case (ph)
        P_IDLE, P_DONE, P_JUMP: if (bus.trigger) begin
          nph = P_ARM;
          e_tv <= 0;
          e_js <= 0;
        end
        P_ARM: begin
          nph = P_COUNT;
          lamps <= 0;
        end
        P_COUNT, P_HOLD: if (bus.react) begin
          nph = P_JUMP;
          e_js <= 1;
          lamps <= 0;
        end else if (ph == P_COUNT && k == 8 * T) begin
          nph = P_HOLD;
          e_hold <= seq[m_cyc];
        end else if (ph == P_HOLD && k == dur - 1) begin
          nph = P_TIMING;
          lamps <= 0;
        end else if (x_en) begin
          lamps <= lamps + 1;
        end
        P_TIMING: if (bus.react) begin
          nph = P_DONE;
          e_rt16 <= k > 65535 ? 65535 : k;
          e_rt4 <= k > 15 ? 15 : k;
          e_tv <= 1;
        end
        default: nph = P_IDLE;
      endcase
    end
    ph <= nph;
    k <= (nph == ph && !rst) ? k + 1 : 0;
    m_cyc <= rst ? 0 : (m_cyc + 1) % 127;
  end

  task automatic wait_lights(input logic [7:0] v, input bit noise);
    int i = 0;
    while (bus.lights_in !== v && i < 2000) begin
      @(posedge clk);
      #1;
      if (noise) bus.trigger = 1'($urandom_range(0, 1));
      i++;
    end
    bus.trigger = 0;
    if (i == 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_lights timeout: lights_in=%h required %h", bus.lights_in, v);
    end
  endtask

  task automatic start_run();
    repeat ($urandom_range(1, 12)) @(posedge clk);
    #1;
    while (used[seq[(m_cyc + 2 + 8 * T) % 127]]) begin
      @(posedge clk);
      #1;
    end
    bus.trigger = 1;
    @(posedge clk);
    #1;
    bus.trigger = 0;
  endtask

  task automatic hold_phase(output int h);
    int n = 0;
    wait_lights(8'hFF, 1);
    @(posedge clk);
    #1;
    h = int'(bus.hold_ticks);
    while (bus.lights_in !== 8'h00 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_len", n, (DMIN + h) * T);
  endtask

  task automatic react_after(input int r);
    repeat (r) @(posedge clk);
    #1;
    bus.react = 1;
    @(posedge clk);
    #1;
    bus.react = 0;
    @(negedge clk);
    chk("react_time_lit", bus.reaction_time, r);
    chk("react_time_w4_lit", bus4.reaction_time, r > 15 ? 15 : r);
    chk("time_valid_lit", bus.time_valid, 1);
    chk("busy_done_lit", bus.busy, 0);
  endtask

  initial begin
    int h1, h2, h3, h4, h, n;
    bus.trigger = 0;
    bus.react = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_hold_ticks", bus.hold_ticks, 0);
    chk("reset_reaction_time", bus.reaction_time, 0);
    chk("reset_time_valid", bus.time_valid, 0);
    chk("reset_jump_start", bus.jump_start, 0);
    chk("reset_light_rst", bus.light_rst, 0);
    repeat (99) @(posedge clk);
    #1 bus.trigger = 1;
    @(posedge clk);
    #1 bus.trigger = 0;
    @(negedge clk);
    chk("arm_light_rst", bus.light_rst, 1);
    chk("arm_busy", bus.busy, 1);
    @(negedge clk);
    chk("arm_light_rst_once", bus.light_rst, 0);
    hold_phase(h1);
    chk("hold_ticks_first", h1, 7'h41);
    used[h1] = 1;
    react_after(37);
    @(posedge clk);
    #1 bus.trigger = 1;
    @(posedge clk);
    #1 bus.trigger = 0;
    @(negedge clk);
    chk("time_valid_clear", bus.time_valid, 0);
    wait_lights(8'h07, 0);
    bus.react = 1;
    @(negedge clk);
    chk("jump_light_rst", bus.light_rst, 1);
    chk("jump_light_en", bus.light_en, 0);
    @(posedge clk);
    #1 bus.react = 0;
    @(negedge clk);
    chk("jump_start_lit", bus.jump_start, 1);
    chk("jump_lights", lights16, 8'h00);
    chk("jump_busy", bus.busy, 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(bus.light_en);
    end
    chk("no_en_after_jump", n, 0);
    @(posedge clk);
    #1 bus.trigger = 1;
    @(posedge clk);
    #1 bus.trigger = 0;
    @(negedge clk);
    chk("jump_start_clear", bus.jump_start, 0);
    chk("restart_busy", bus.busy, 1);
    hold_phase(h2);
    used[h2] = 1;
    react_after(20);
    start_run();
    hold_phase(h3);
    used[h3] = 1;
    react_after($urandom_range(0, 40));
    start_run();
    hold_phase(h4);
    used[h4] = 1;
    react_after($urandom_range(0, 40));
    chk("h_differ_13", h1 != h3, 1);
    chk("h_differ_34", h3 != h4, 1);
    chk("h_differ_14", h1 != h4, 1);
    chk("h_nonzero", h3 != 0 && h4 != 0, 1);
    start_run();
    wait_lights(8'hFF, 1);
    @(posedge clk);
    #1 h = int'(bus.hold_ticks);
    repeat ((DMIN + h) * T - 1) @(posedge clk);
    #1 bus.react = 1;
    @(negedge clk);
    chk("final_tick_light_en", bus.light_en, 0);
    chk("final_tick_light_rst", bus.light_rst, 1);
    @(posedge clk);
    #1 bus.react = 0;
    @(negedge clk);
    chk("final_tick_jump", bus.jump_start, 1);
    chk("final_tick_lights", lights16, 8'h00);
    repeat (8) @(negedge clk);
    start_run();
    wait_lights(8'hFF, 1);
    repeat (5) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_light_en", bus.light_en, 0);
    chk("rst_light_rst", bus.light_rst, 0);
    chk("rst_hold_ticks", bus.hold_ticks, 0);
    chk("rst_reaction_time", bus.reaction_time, 0);
    chk("rst_time_valid", bus.time_valid, 0);
    chk("rst_jump_start", bus.jump_start, 0);
    chk("rst_lights", lights16, 8'h00);
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end, %0d compared so far", n_cmp);
    $fatal(1);
  end
endmodule
